// File: rtl/i2c_slave_mem_if.sv
// rtl/i2c_slave_mem_if.sv - open-drain I2C bus signals seen by the slave memory
interface i2c_slave_mem_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe
  );

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C slave target fronting a 64 x 8 register memory
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h01,
  parameter int         MEM_AW   = 6
) (
  input  logic              clk8x,
  input  logic              reset,
  i2c_slave_mem_if.slave    bus,
  output logic              busy,
  output logic [3:0]        state,
  output logic              wr_strobe,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              rw_q;
  logic [MEM_AW-1:0] ptr_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic              wr_strobe_q;
  logic [7:0]        mem_q [DEPTH];

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Two-flop synchronisers plus a history flop; idle bus level is high
  always_ff @(posedge clk8x) begin
    if (reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= bus.scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= bus.sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
  // Byte as it will look once the bit sampled on this rise is shifted in
  assign rx_byte   = {shift_q[6:0], sda_s2_q};

  // Protocol FSM with registered SDA drive, busy flag, write strobe and memory
  always_ff @(posedge clk8x) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_det) begin
        state_q   <= ST_IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else if (start_det) begin
        state_q   <= ST_DEV_ADDR;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
        bit_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_DEV_ADDR: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_q    <= rx_byte[0];
                  state_q <= ST_DEV_ACK;
                end else begin
                  state_q <= ST_WAIT_STOP;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          // Ack states: first fall starts the ACK, second fall ends it
          ST_DEV_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_MEM_ADDR;
              end
            end
          end
          ST_MEM_ADDR: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                ptr_q     <= rx_byte[MEM_AW-1:0];
                state_q   <= ST_MEM_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_MEM_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (rw_q) begin
                shift_q   <= mem_q[ptr_q];
                sda_oe_q  <= ~mem_q[ptr_q][7];
                bit_cnt_q <= 4'd0;
                state_q   <= ST_RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q    <= 4'd0;
                mem_q[ptr_q] <= rx_byte;
                wr_strobe_q  <= 1'b1;
                ptr_q        <= ptr_q + 1'b1;
                state_q      <= ST_WR_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_WR_DATA;
              end
            end
          end
          // MSB is already on the bus at entry; each fall presents the next bit
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) ptr_q <= ptr_q + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= ST_RD_ACK;
              end else if (bit_cnt_q != 4'd0) begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2_q) state_q <= ST_WAIT_STOP;
              else          bit_cnt_q <= 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              shift_q   <= mem_q[ptr_q];
              sda_oe_q  <= ~mem_q[ptr_q][7];
              bit_cnt_q <= 4'd0;
              state_q   <= ST_RD_DATA;
            end
          end
          ST_WAIT_STOP: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign state      = state_q;
  assign wr_strobe  = wr_strobe_q;
  assign dbg_data   = mem_q[dbg_addr];
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - scoreboard bench for i2c_slave_mem with a byte-level memory model
module tb_i2c_slave_mem;
  localparam int         Q           = 4;
  localparam logic [6:0] DEV         = 7'h01;
  localparam int         S_IDLE      = 0;
  localparam int         S_DEV_ADDR  = 1;
  localparam int         S_RD_DATA   = 7;
  localparam int         S_WAIT_STOP = 9;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk8x = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] state;
  logic [5:0] dbg_addr = 6'd0;
  logic [7:0] dbg_data;

  logic [7:0] model [64];
  logic       oe_q [$];
  wr_t        wr_q [$];
  logic [7:0] tx_q [$];
  int         n_checks = 0;
  int         n_errors = 0;

  i2c_slave_mem_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_slave_mem #(.DEV_ADDR(7'h01), .MEM_AW(6)) dut (
    .clk8x     (clk8x),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .state     (state),
    .wr_strobe (wr_strobe),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk8x = ~clk8x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk8x);
  endtask

  // One SCL pulse carrying master bit b; exp_oe is what the slave must drive while SCL is high
  task automatic clk_bit(input logic b, input logic exp_oe);
    oe_q.push_back(exp_oe);
    m_sda = b;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(2 * Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b0;
    wait_clks(2 * Q);
    m_scl = 1'b0;
    wait_clks(Q);
    check("busy_after_start", busy, 1);
  endtask

  task automatic do_stop();
    oe_q.push_back(1'b0);
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda = 1'b1;
    wait_clks(2 * Q);
    check("state_after_stop", state, S_IDLE);
    check("busy_after_stop", busy, 0);
  endtask

  task automatic do_rstart();
    oe_q.push_back(1'b0);
    m_sda = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
    check("state_after_rstart", state, S_DEV_ADDR);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack_exp);
    for (int i = 7; i >= 0; i--) clk_bit(d[i], 1'b0);
    clk_bit(1'b1, ack_exp);
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic master_ack);
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, ~exp_d[i]);
    clk_bit(~master_ack, 1'b0);
  endtask

  task automatic write_frame(input logic [6:0] dev, input logic [7:0] addr);
    logic       hit;
    logic [5:0] p;
    wr_t        w;
    hit = (dev == DEV);
    p = addr[5:0];
    do_start();
    send_byte({dev, 1'b0}, hit);
    send_byte(addr, hit);
    foreach (tx_q[i]) begin
      if (hit) begin
        w.a = p;
        w.d = tx_q[i];
        wr_q.push_back(w);
        model[p] = tx_q[i];
        p = p + 6'd1;
      end
      send_byte(tx_q[i], hit);
    end
    do_stop();
  endtask

  task automatic read_frame(input logic [7:0] addr, input int n);
    logic [5:0] p;
    p = addr[5:0];
    do_start();
    send_byte({DEV, 1'b1}, 1'b1);
    send_byte(addr, 1'b1);
    for (int k = 0; k < n; k++) begin
      recv_byte(model[p], k < n - 1);
      p = p + 6'd1;
    end
    check("rd_wait_stop", state, S_WAIT_STOP);
    do_stop();
  endtask

  task automatic abort_frame(input logic [7:0] addr, input logic [7:0] d, input int nbits, input logic restart);
    do_start();
    send_byte({DEV, 1'b0}, 1'b1);
    send_byte(addr, 1'b1);
    for (int i = 0; i < nbits; i++) clk_bit(d[7 - i], 1'b0);
    if (restart) do_rstart();
    do_stop();
    dbg_addr = addr[5:0];
    #1;
    check("abort_mem", dbg_data, model[addr[5:0]]);
  endtask

  task automatic sweep_mem();
    for (int a = 0; a < 64; a++) begin
      dbg_addr = a[5:0];
      #1;
      check("mem_sweep", dbg_data, model[a]);
    end
  endtask

  // Slave SDA drive is checked against the expected value in the middle of every SCL high
  initial begin : oe_mon
    logic e_oe;
    wait_clks(3);
    forever begin
      @(posedge bus.scl_in);
      wait_clks(2);
      if (oe_q.size() == 0) begin
        check("oe_unexpected", bus.sda_oe, 0);
      end else begin
        e_oe = oe_q.pop_front();
        check("sda_oe_bit", bus.sda_oe, e_oe);
      end
    end
  end

  // Every write strobe must match the next expected write and land in memory
  initial begin : wr_mon
    wr_t e;
    wait_clks(3);
    forever begin
      @(negedge clk8x);
      if (wr_strobe === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("wr_strobe_unexpected", wr_strobe, 0);
        end else begin
          e = wr_q.pop_front();
          dbg_addr = e.a;
          #1;
          check("wr_data", dbg_data, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int op, n;
    logic [7:0] a;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    wait_clks(4);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, S_IDLE);
    check("rst_wr_strobe", wr_strobe, 0);
    reset = 1'b0;
    wait_clks(4);
    sweep_mem();

    tx_q = {8'h5F};
    write_frame(7'h01, 8'h01);
    read_frame(8'h01, 1);
    tx_q = {8'hAA};
    write_frame(7'h02, 8'h05);
    tx_q = {8'h11, 8'h22};
    write_frame(7'h01, 8'h3F);
    read_frame(8'h3F, 2);
    abort_frame(8'h10, 8'hC3, 4, 1'b0);
    abort_frame(8'h10, 8'hC3, 3, 1'b1);

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      a  = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 3);
      tx_q = {};
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      case (op)
        0: write_frame(DEV, a);
        1: read_frame(a, n);
        2: write_frame(7'($urandom_range(2, 127)), a);
        default: abort_frame(a, tx_q[0], $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      endcase
    end
    sweep_mem();

    tx_q = {8'h3C};
    write_frame(DEV, 8'h20);
    do_start();
    send_byte({DEV, 1'b1}, 1'b1);
    send_byte(8'h20, 1'b1);
    wait_clks(1);
    check("pre_rst_state", state, S_RD_DATA);
    check("pre_rst_sda_oe", bus.sda_oe, 1);
    reset = 1'b1;
    @(posedge clk8x);
    #1;
    check("mid_rst_sda_oe", bus.sda_oe, 0);
    check("mid_rst_state", state, S_IDLE);
    check("mid_rst_busy", busy, 0);
    oe_q.push_back(1'b0);
    m_sda = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(2 * Q);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    wait_clks(4);
    sweep_mem();

    wait_clks(10);
    check("oe_q_drained", oe_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
